rob: RTL
========

# rob

Reorder buffer for the out-of-order core. Allocates one in-order entry per dispatched instruction and returns its ROB id to the rename table. Captures results from the common data bus (CDB), supplies ready operands to dispatch by ROB id, and retires completed entries in program order. The commit port drives both the architectural register file write and the rename-table release.

## Interface

**Parameters**
- `ROB_DEPTH`, 16: number of entries; must be a power of two.
- `ROB_PTR_W`, $clog2(ROB_DEPTH): ROB id width.
- `DATA_W`, 32: result width.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: synchronous squash of all entries.
- `alloc_valid` in 1: dispatch requests an entry.
- `alloc_ready` out 1: an entry is free.
- `alloc_rd_addr` in 5: destination architectural register.
- `alloc_rob_id` out ROB_PTR_W: id assigned to the current request (the tail index).
- `cdb_valid` in 1: result broadcast.
- `cdb_rob_id` in ROB_PTR_W: producing entry.
- `cdb_data` in DATA_W: result value.
- `rs1_rob_id`, `rs2_rob_id` in ROB_PTR_W: operand lookup ids, taken from the rename table.
- `rs1_ready`, `rs2_ready` out 1: the looked-up entry holds a result.
- `rs1_data`, `rs2_data` out DATA_W: that result.
- `commit` out 1: the head entry retires this cycle.
- `commit_rob_id` out ROB_PTR_W: head index.
- `commit_rd_addr` out 5: destination of the retiring entry.
- `commit_data` out DATA_W: value of the retiring entry.

## Operation

**Storage**
- Per-entry fields: `valid`, `done`, `rd_addr`, `data`.
- `head` and `tail` are ROB_PTR_W+1 bits wide. The MSB is a wrap bit.
- Empty: `head == tail`. Full: indices are equal and the wrap bits differ.

**Allocate**
- `alloc_ready = !full`. There is no same-cycle bypass from commit when full.
- Fire = `alloc_valid && alloc_ready`.
- On fire: entry[tail] gets `valid=1`, `done=0`, `rd_addr`, then tail increments modulo 2·ROB_DEPTH.
- `alloc_rob_id` = tail index at all times, combinationally.

**Writeback**
- On `cdb_valid`, if entry[cdb_rob_id].valid: set `done=1` and `data=cdb_data`.
- A CDB write to an invalid entry is ignored.

**Operand read**
- `rsX_ready = entry.valid && entry.done`, combinational.
- CDB bypass: if `cdb_valid` and `cdb_rob_id == rsX_rob_id` and the entry is valid, then `rsX_ready=1` and `rsX_data=cdb_data` in the same cycle.
- When not ready, `rsX_data` is don't-care. The bench must not check it.

**Commit**
- `commit = entry[head].valid && entry[head].done && !flush`. It reflects registered state only; there is no CDB bypass into commit.
- `commit_*` outputs come from entry[head].
- On commit: entry[head].valid clears and head increments.
- An entry with `rd_addr == 0` still commits; the register file discards the write.

**Same-cycle combinations**
- Alloc and commit together: both pointers advance and the count is unchanged. This is legal when full only if an entry was already free (alloc_ready is decided by the pre-commit state).
- Alloc into a slot freed by the same-cycle commit cannot occur, since alloc_ready=0 when full.

**Priority and reset**
- Priority: `rst` > `flush` > alloc/writeback/commit.
- `flush`: all `valid`/`done` clear, head=tail=0. That cycle's alloc and CDB are dropped, and `commit` is 0 in the flush cycle.
- Reset state: head=tail=0 and every `valid`/`done`=0. Hence `alloc_ready=1`, `alloc_rob_id=0`, `commit=0`, `rs1_ready=rs2_ready=0`.
- `rd_addr` and `data` are not reset.
- Reset asserted mid-operation discards all in-flight entries on the next edge.

## Timing

- Alloc fires at cycle N. The id is visible during N; the entry is valid from N+1.
- CDB write at cycle N:
  - operands see the result in N via bypass;
  - `done` is registered at N+1;
  - earliest commit is N+1, if the entry is at head.
- Throughput: one alloc, one writeback and one commit per cycle.
- Minimum allocate-to-commit latency is 2 cycles (alloc N, CDB N+1, commit N+2).
- All outputs are combinational from registered state plus the CDB and lookup inputs. There are no combinational paths from `alloc_valid` to any output.

## Test plan

- **Reset:** assert rst 2 cycles → alloc_ready=1, alloc_rob_id=0, commit=0, rs1_ready=0.
- **Fill:** 16 allocs with rd=1..16 and no CDB → ids 0..15, then alloc_ready=0. A 17th alloc_valid leaves tail unchanged.
- **Out-of-order writeback:**
  - CDB id 2 (0xB), then id 1 (0xA), then id 0 (0x9);
  - expect no commit until id 0 is done;
  - then commit on three consecutive cycles with data 0x9, 0xA, 0xB and rd 1, 2, 3.
- **Bypass:** rs1_rob_id=5 with entry 5 pending; CDB id 5 data 0xDEAD in the same cycle → rs1_ready=1, rs1_data=0xDEAD that cycle. Expect commit no earlier than the next cycle.
- **Wrap and full edge:**
  - run 40 instructions through with simultaneous alloc and commit;
  - verify ids wrap 15→0 and head/tail wrap bits toggle;
  - with the buffer full, do a commit plus alloc_valid → no alloc that cycle; alloc succeeds the next cycle.
- **Flush:** 5 entries valid, 2 done at head; assert flush together with a CDB and an alloc → commit=0, and the next cycle shows an empty buffer with alloc_rob_id=0 and rs ready=0.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, CDB writeback with operand bypass,
// and in-order commit to the architectural register file.
module rob #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [4:0]           alloc_rd_addr,
    output logic [ROB_PTR_W-1:0] alloc_rob_id,
    input  logic                 cdb_valid,
    input  logic [ROB_PTR_W-1:0] cdb_rob_id,
    input  logic [DATA_W-1:0]    cdb_data,
    input  logic [ROB_PTR_W-1:0] rs1_rob_id,
    input  logic [ROB_PTR_W-1:0] rs2_rob_id,
    output logic                 rs1_ready,
    output logic                 rs2_ready,
    output logic [DATA_W-1:0]    rs1_data,
    output logic [DATA_W-1:0]    rs2_data,
    output logic                 commit,
    output logic [ROB_PTR_W-1:0] commit_rob_id,
    output logic [4:0]           commit_rd_addr,
    output logic [DATA_W-1:0]    commit_data
);

    typedef logic [ROB_PTR_W-1:0] idx_t;
    typedef logic [ROB_PTR_W:0]   ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);

    // Pointers carry an extra wrap bit to tell full from empty.
    ptr_t                 head;
    ptr_t                 tail;
    logic [ROB_DEPTH-1:0] valid;
    logic [ROB_DEPTH-1:0] done;
    logic [4:0]           rd_q   [ROB_DEPTH];
    logic [DATA_W-1:0]    data_q [ROB_DEPTH];

    idx_t head_idx;
    idx_t tail_idx;
    logic full;
    logic alloc_fire;
    logic cdb_hit;
    logic rs1_byp;
    logic rs2_byp;

    assign head_idx = head[ROB_PTR_W-1:0];
    assign tail_idx = tail[ROB_PTR_W-1:0];

    // Full when indices match but the wrap bits differ.
    assign full = (head_idx == tail_idx) &&
                  (head[ROB_PTR_W] != tail[ROB_PTR_W]);

    assign alloc_ready  = !full;
    assign alloc_rob_id = tail_idx;
    assign alloc_fire   = alloc_valid && !full;

    // Results aimed at squashed or retired slots are dropped.
    assign cdb_hit = cdb_valid && valid[cdb_rob_id];

    assign rs1_byp = cdb_hit && (cdb_rob_id == rs1_rob_id);
    assign rs2_byp = cdb_hit && (cdb_rob_id == rs2_rob_id);

    assign rs1_ready = (valid[rs1_rob_id] && done[rs1_rob_id]) || rs1_byp;
    assign rs2_ready = (valid[rs2_rob_id] && done[rs2_rob_id]) || rs2_byp;
    assign rs1_data  = rs1_byp ? cdb_data : data_q[rs1_rob_id];
    assign rs2_data  = rs2_byp ? cdb_data : data_q[rs2_rob_id];

    // Retirement looks only at registered state; no CDB shortcut.
    assign commit = valid[head_idx] && done[head_idx] && !flush;

    assign commit_rob_id  = head_idx;
    assign commit_rd_addr = rd_q[head_idx];
    assign commit_data    = data_q[head_idx];

    // Control state: pointers and per-entry valid/done flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (cdb_hit) begin
                done[cdb_rob_id] <= 1'b1;
            end
            if (alloc_fire) begin
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= 1'b0;
                tail            <= tail + PTR_ONE;
            end
            if (commit) begin
                valid[head_idx] <= 1'b0;
                head            <= head + PTR_ONE;
            end
        end
    end

    // Payload storage: destination and result, left unreset.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (alloc_fire) begin
                rd_q[tail_idx] <= alloc_rd_addr;
            end
            if (cdb_hit) begin
                data_q[cdb_rob_id] <= cdb_data;
            end
        end
    end

endmodule
